sync_event_capture: RTL and testbench
=====================================

Name: sync_event_capture

Overview:
- Sits directly downstream of the two-flop clkA->clkB synchronizer and consumes its synchronized level output.
- Runs entirely in the clkB domain.
- Filters the synchronized level so that short pulses are rejected, then detects rising and falling edges of the filtered level.
- Queues edge events in a small FIFO behind a valid/ready handshake, and keeps a saturating count of edges plus a sticky overflow flag.

Parameters:
STABLE_CYCLES, 2, consecutive clkB samples of a new level required before it is accepted (>=1)
DEPTH, 4, event FIFO depth in entries (power of 2, >=2)
CNT_W, 8, width of the edge counter

Ports:
clkB  in  1  clkB-domain clock, rising edge
rstB  in  1  synchronous active-high reset
sig_in  in  1  synchronized level from the 2-flop synchronizer
evt_ready  in  1  consumer accepts the head event
clr_count  in  1  synchronous clear of evt_count and overflow
level_out  out  1  filtered level
rise_pulse  out  1  one-cycle strobe on a filtered 0->1 transition
fall_pulse  out  1  one-cycle strobe on a filtered 1->0 transition
evt_valid  out  1  FIFO non-empty; head event presented
evt_rise  out  1  head event kind: 1 = rise, 0 = fall; meaningful only while evt_valid
evt_count  out  CNT_W  saturating count of filtered edges
overflow  out  1  sticky: an edge was dropped because the FIFO was full

Behaviour:
- Reset, taken on a clkB edge with rstB=1:
  - level_out=0, rise_pulse=0, fall_pulse=0.
  - Stability counter=0, FIFO empty, evt_valid=0, evt_count=0, overflow=0.
  - Reset asserted mid-operation discards all queued events and any stability count in progress.
- Filter: internal stab_cnt, range 0..STABLE_CYCLES-1. At each posedge:
  - If sig_in==level_out: stab_cnt<=0.
  - Else if stab_cnt==STABLE_CYCLES-1: level_out<=sig_in, stab_cnt<=0, and the internal edge strobe e fires this cycle.
  - Else: stab_cnt<=stab_cnt+1.
  - Net effect: level_out updates at the STABLE_CYCLES-th consecutive posedge that samples the new value. A pulse shorter than that produces no change.
- Edge strobes:
  - rise_pulse and fall_pulse are registered on the same posedge as the level_out update.
  - Each is high for exactly one cycle. They are never high together.
- If sig_in=1 when reset is released, the result is a normal rise after STABLE_CYCLES cycles. It is counted and queued.
- Event FIFO: push on e with data = new level (1 = rise).
  - evt_valid = not empty. evt_rise = head entry.
  - Pop happens on a posedge with evt_valid && evt_ready.
  - An event pushed into an empty FIFO is visible in the same cycle rise_pulse or fall_pulse is high. There are no extra latency stages.
  - Full + push + pop on the same cycle: both occur, no overflow, occupancy unchanged.
  - Full + push with no pop: the event is dropped, overflow<=1, and the existing contents are untouched.
  - Empty + pop request: no effect, because evt_valid=0.
  - Events leave the FIFO in arrival order.
- evt_count: increments on every e, whether the event was queued or dropped. It saturates at 2^CNT_W-1 and does not wrap.
- clr_count:
  - Sets evt_count<=0 and overflow<=0.
  - If e occurs in the same cycle, clear wins: the count ends at 0 and overflow ends at 0. The event itself is still pushed into the FIFO if there is room.
  - clr_count does not flush the FIFO.
- overflow is cleared only by rstB or clr_count.

Decomposition:
- Package sync_evt_pkg contains:
  - enum evt_kind_e with EVT_FALL=0 and EVT_RISE=1;
  - default constants for STABLE_CYCLES, DEPTH and CNT_W.
- One sub-module, sync_evt_fifo:
  - DEPTH x 1-bit storage, synchronous active-high reset.
  - Interface: push, pop, full and empty flags, head data output.
  - Pointers are log2(DEPTH)+1 bits wide; full/empty are decided by the MSB.
- The filter, edge strobes, counter and overflow logic all live in the top module.

Test Plan:
All scenarios use STABLE_CYCLES=2, DEPTH=4, CNT_W=8 unless stated otherwise.
- Reset: rstB=1 for 3 cycles with sig_in=0 -> every output is 0. Then assert rstB for 1 cycle mid-stream with 3 events queued -> evt_valid=0 and evt_count=0 on the next cycle.
- Clean rise: sig_in 0->1 and held, evt_ready=1 -> level_out, rise_pulse and evt_valid (evt_rise=1) all go high at the 2nd posedge that samples 1. rise_pulse lasts 1 cycle. evt_count=1. evt_valid drops the next cycle.
- Glitch reject: sig_in=1 for exactly 1 cycle, then 0 -> level_out stays 0, no strobes, evt_count=0, evt_valid=0.
- Backpressure: evt_ready=0, 5 stable alternating edges -> the FIFO holds rise,fall,rise,fall; overflow=1 after the 5th edge; evt_count=5. Then evt_ready=1 -> exactly 4 events drain in that order over 4 cycles.
- Full with simultaneous pop+push: FIFO full, evt_ready=1 in the same cycle as a new edge -> overflow stays 0, occupancy stays 4, and the new event appears last in the drain order.
- Saturation and clear, with CNT_W=4: 20 stable edges -> evt_count=15. Then clr_count coincident with a new edge -> evt_count=0 and overflow=0 the next cycle, and that edge is still present in the FIFO.

Source files
------------

// File: rtl/sync_evt_pkg.sv
// ---------------------------------------------------------------------------
// | Module   : sync_evt_pkg                                                  |
// | Brief    : Shared event kind and default sizing for sync_event_capture.  |
// | Revision : 1.0                                                           |
// ---------------------------------------------------------------------------
`default_nettype none

package sync_evt_pkg;

   typedef enum logic {
      EVT_FALL = 1'b0,
      EVT_RISE = 1'b1
   } evt_kind_e;

   localparam int unsigned c_defStableCycles = 2;
   localparam int unsigned c_defDepth        = 4;
   localparam int unsigned c_defCntW         = 8;

endpackage

`default_nettype wire

// File: rtl/sync_evt_fifo.sv
// ---------------------------------------------------------------------------
// | Module   : sync_evt_fifo                                                 |
// | Brief    : DEPTH x 1-bit event FIFO, MSB-wrap pointers, show-ahead head. |
// | Revision : 1.0                                                           |
// ---------------------------------------------------------------------------
`default_nettype none

module sync_evt_fifo
   import sync_evt_pkg::*;
#(
   parameter int unsigned DEPTH = c_defDepth
)(
   input  logic clkB,
   input  logic rstB,
   input  logic push,
   input  logic pushData,
   input  logic pop,
   output logic full,
   output logic empty,
   output logic headData
);

   localparam int unsigned       c_aw     = $clog2(DEPTH);
   localparam logic [c_aw:0]     c_ptrOne = {{c_aw{1'b0}}, 1'b1};

   logic [c_aw:0]    r_wrPtr;
   logic [c_aw:0]    r_rdPtr;
   logic [DEPTH-1:0] r_mem;
   logic             w_doPush;
   logic             w_doPop;

   assign empty    = (r_wrPtr == r_rdPtr);
   assign full     = (r_wrPtr[c_aw] != r_rdPtr[c_aw]) &&
                     (r_wrPtr[c_aw-1:0] == r_rdPtr[c_aw-1:0]);
   assign w_doPop  = pop && !empty;
   // A pop on the same edge frees the slot the write lands in.
   assign w_doPush = push && (!full || w_doPop);
   assign headData = r_mem[r_rdPtr[c_aw-1:0]];

   always_ff @(posedge clkB) begin
      if (rstB) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_mem   <= '0;
      end else begin
         if (w_doPush) begin
            r_mem[r_wrPtr[c_aw-1:0]] <= pushData;
            r_wrPtr                  <= r_wrPtr + c_ptrOne;
         end
         if (w_doPop) begin
            r_rdPtr <= r_rdPtr + c_ptrOne;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/sync_event_capture.sv
// ---------------------------------------------------------------------------
// | Module   : sync_event_capture                                            |
// | Brief    : Glitch filter, edge strobes, event FIFO and edge counter.     |
// | Revision : 1.0                                                           |
// ---------------------------------------------------------------------------
`default_nettype none

module sync_event_capture
   import sync_evt_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = c_defStableCycles,
   parameter int unsigned DEPTH         = c_defDepth,
   parameter int unsigned CNT_W         = c_defCntW
)(
   input  logic             clkB,
   input  logic             rstB,
   input  logic             sig_in,
   input  logic             evt_ready,
   input  logic             clr_count,
   output logic             level_out,
   output logic             rise_pulse,
   output logic             fall_pulse,
   output logic             evt_valid,
   output logic             evt_rise,
   output logic [CNT_W-1:0] evt_count,
   output logic             overflow
);

   localparam int unsigned      c_scW     = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [c_scW-1:0] c_stabMax = c_scW'(STABLE_CYCLES - 1);
   localparam logic [c_scW-1:0] c_stabOne = c_scW'(1);
   localparam logic [CNT_W-1:0] c_cntMax  = '1;
   localparam logic [CNT_W-1:0] c_cntOne  = CNT_W'(1);

   logic [c_scW-1:0] r_stabCnt;
   logic             r_level;
   logic             r_rise;
   logic             r_fall;
   logic [CNT_W-1:0] r_count;
   logic             r_overflow;

   logic             w_edge;
   logic             w_drop;
   logic             w_full;
   logic             w_empty;
   logic             w_head;
   evt_kind_e        w_pushKind;

   assign w_edge     = (sig_in != r_level) && (r_stabCnt == c_stabMax);
   assign w_pushKind = sig_in ? EVT_RISE : EVT_FALL;
   // Full implies non-empty, so the only way to make room is a ready consumer.
   assign w_drop     = w_edge && w_full && !evt_ready;

   always_ff @(posedge clkB) begin
      if (rstB) begin
         r_stabCnt  <= '0;
         r_level    <= 1'b0;
         r_rise     <= 1'b0;
         r_fall     <= 1'b0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_rise <= w_edge && sig_in;
         r_fall <= w_edge && !sig_in;
         if (sig_in == r_level) begin
            r_stabCnt <= '0;
         end else if (w_edge) begin
            r_level   <= sig_in;
            r_stabCnt <= '0;
         end else begin
            r_stabCnt <= r_stabCnt + c_stabOne;
         end
         if (clr_count) begin
            r_count    <= '0;
            r_overflow <= 1'b0;
         end else begin
            if (w_edge && (r_count != c_cntMax)) begin
               r_count <= r_count + c_cntOne;
            end
            if (w_drop) begin
               r_overflow <= 1'b1;
            end
         end
      end
   end

   sync_evt_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clkB     (clkB),
      .rstB     (rstB),
      .push     (w_edge),
      .pushData (w_pushKind == EVT_RISE),
      .pop      (evt_ready),
      .full     (w_full),
      .empty    (w_empty),
      .headData (w_head)
   );

   assign level_out  = r_level;
   assign rise_pulse = r_rise;
   assign fall_pulse = r_fall;
   assign evt_valid  = !w_empty;
   assign evt_rise   = w_head;
   assign evt_count  = r_count;
   assign overflow   = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_sync_event_capture.sv
// ---------------------------------------------------------------------------
// | Module   : tb_sync_event_capture                                         |
// | Brief    : Directed bench with event scoreboard for sync_event_capture.  |
// | Revision : 1.0                                                           |
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sync_event_capture;
   import sync_evt_pkg::*;

   logic       clkB = 1'b0;
   logic       rstB, sigIn, evtReady, clrCount;
   logic       levelOut, risePulse, fallPulse, evtValid, evtRise, overflow;
   logic [7:0] evtCount;
   logic       sLevel, sRise, sFall, sValid, sEvtRise, sOverflow;
   logic [3:0] sCount;

   int        total = 0;
   int        bad   = 0;
   evt_kind_e expQ[$];

   always #5 clkB = ~clkB;

   sync_event_capture dut (
      .clkB(clkB), .rstB(rstB), .sig_in(sigIn), .evt_ready(evtReady), .clr_count(clrCount),
      .level_out(levelOut), .rise_pulse(risePulse), .fall_pulse(fallPulse),
      .evt_valid(evtValid), .evt_rise(evtRise), .evt_count(evtCount), .overflow(overflow)
   );

   sync_event_capture #(.STABLE_CYCLES(2), .DEPTH(4), .CNT_W(4)) dutS (
      .clkB(clkB), .rstB(rstB), .sig_in(sigIn), .evt_ready(evtReady), .clr_count(clrCount),
      .level_out(sLevel), .rise_pulse(sRise), .fall_pulse(sFall),
      .evt_valid(sValid), .evt_rise(sEvtRise), .evt_count(sCount), .overflow(sOverflow)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clkB);
      #1;
   endtask

   task automatic chkState(input string tag, input logic lv, input logic r, input logic f);
      chk({tag, "_level"}, levelOut, lv);
      chk({tag, "_rise"}, risePulse, r);
      chk({tag, "_fall"}, fallPulse, f);
      chk({tag, "_s_level"}, sLevel, lv);
      chk({tag, "_s_rise"}, sRise, r);
      chk({tag, "_s_fall"}, sFall, f);
   endtask

   // Holds sig_in at v for two samples; the second posedge is the filtered edge.
   task automatic doEdge(input logic v, input bit queued);
      sigIn = v;
      tick();
      if (queued) expQ.push_back(v ? EVT_RISE : EVT_FALL);
      tick();
   endtask

   // Scoreboard monitor: every accepted handshake must match the oldest expectation.
   initial begin
      evt_kind_e e;
      forever begin
         @(negedge clkB);
         if (rstB === 1'b0 && evtValid === 1'b1 && evtReady === 1'b1) begin
            if (expQ.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_event: got kind %0d expected none", evtRise);
            end else begin
               e = expQ.pop_front();
               chk("evt_kind", evtRise, e);
               chk("s_evt_kind", sEvtRise, e);
               chk("s_evt_valid", sValid, 1);
            end
         end
      end
   end

   initial begin
      rstB = 1'b1; sigIn = 1'b0; evtReady = 1'b0; clrCount = 1'b0;
      repeat (3) tick();
      chkState("reset", 0, 0, 0);
      chk("reset_valid", evtValid, 0);
      chk("reset_count", evtCount, 0);
      chk("reset_ovf", overflow, 0);
      chk("reset_s_count", sCount, 0);
      chk("reset_s_ovf", sOverflow, 0);
      rstB = 1'b0;

      // clean rise
      evtReady = 1'b1; sigIn = 1'b1;
      tick();
      chkState("rise_wait", 0, 0, 0);
      chk("rise_wait_valid", evtValid, 0);
      expQ.push_back(EVT_RISE);
      tick();
      chkState("rise", 1, 1, 0);
      chk("rise_valid", evtValid, 1);
      chk("rise_count", evtCount, 1);
      tick();
      chkState("rise_after", 1, 0, 0);
      chk("rise_drained", evtValid, 0);

      doEdge(1'b0, 1'b1);
      chkState("fall", 0, 0, 1);
      chk("fall_count", evtCount, 2);
      clrCount = 1'b1; tick(); clrCount = 1'b0;
      chk("clr_count", evtCount, 0);
      chk("clr_valid", evtValid, 0);

      // one-cycle glitch must be rejected
      sigIn = 1'b1; tick();
      chkState("glitch_a", 0, 0, 0);
      sigIn = 1'b0; tick();
      chkState("glitch_b", 0, 0, 0);
      tick();
      chkState("glitch_c", 0, 0, 0);
      chk("glitch_count", evtCount, 0);
      chk("glitch_valid", evtValid, 0);

      // backpressure: fifth edge dropped
      evtReady = 1'b0;
      doEdge(1'b1, 1'b1); doEdge(1'b0, 1'b1); doEdge(1'b1, 1'b1); doEdge(1'b0, 1'b1);
      chk("bp_ovf_before", overflow, 0);
      doEdge(1'b1, 1'b0);
      chkState("bp5", 1, 1, 0);
      chk("bp_ovf", overflow, 1);
      chk("bp_count", evtCount, 5);
      chk("bp_valid", evtValid, 1);
      evtReady = 1'b1;
      repeat (3) tick();
      chk("bp_valid_3", evtValid, 1);
      tick();
      chk("bp_drained", evtValid, 0);
      chk("bp_q_empty", expQ.size(), 0);
      chk("bp_ovf_sticky", overflow, 1);

      // full FIFO with simultaneous push and pop
      evtReady = 1'b0;
      clrCount = 1'b1; tick(); clrCount = 1'b0;
      chk("fpp_ovf_clr", overflow, 0);
      doEdge(1'b0, 1'b1); doEdge(1'b1, 1'b1); doEdge(1'b0, 1'b1); doEdge(1'b1, 1'b1);
      chk("fpp_full_valid", evtValid, 1);
      sigIn = 1'b0;
      tick();
      evtReady = 1'b1;
      expQ.push_back(EVT_FALL);
      tick();
      chkState("fpp", 0, 0, 1);
      chk("fpp_ovf", overflow, 0);
      chk("fpp_count", evtCount, 5);
      repeat (3) tick();
      chk("fpp_occ_valid", evtValid, 1);
      tick();
      chk("fpp_drained", evtValid, 0);

      // saturation on the 4-bit instance, then clear coincident with an edge
      clrCount = 1'b1; tick(); clrCount = 1'b0;
      for (int i = 0; i < 20; i++) doEdge((i % 2) == 0, 1'b1);
      chk("sat_s_count", sCount, 15);
      chk("sat_count", evtCount, 20);
      tick();
      chk("sat_drained", evtValid, 0);
      evtReady = 1'b0; sigIn = 1'b1;
      tick();
      clrCount = 1'b1;
      expQ.push_back(EVT_RISE);
      tick();
      clrCount = 1'b0;
      chkState("clr_edge", 1, 1, 0);
      chk("clr_edge_s_count", sCount, 0);
      chk("clr_edge_count", evtCount, 0);
      chk("clr_edge_ovf", overflow, 0);
      chk("clr_edge_s_ovf", sOverflow, 0);
      chk("clr_edge_valid", evtValid, 1);
      evtReady = 1'b1;
      tick();
      chk("clr_edge_drained", evtValid, 0);

      // reset mid-stream with queued events, released while sig_in is high
      evtReady = 1'b0;
      doEdge(1'b0, 1'b1); doEdge(1'b1, 1'b1); doEdge(1'b0, 1'b1);
      chk("mid_valid", evtValid, 1);
      chk("mid_count", evtCount, 3);
      sigIn = 1'b1; rstB = 1'b1;
      expQ.delete();
      tick();
      rstB = 1'b0;
      chkState("mid_reset", 0, 0, 0);
      chk("mid_reset_valid", evtValid, 0);
      chk("mid_reset_count", evtCount, 0);
      tick();
      chkState("rel_wait", 0, 0, 0);
      evtReady = 1'b1;
      expQ.push_back(EVT_RISE);
      tick();
      chkState("rel_rise", 1, 1, 0);
      chk("rel_count", evtCount, 1);
      tick();
      chk("rel_drained", evtValid, 0);
      chk("final_q_empty", expQ.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
